// File: rtl/eth_sd_sector_writer.sv
// Turns show-ahead FIFO words into 512-byte SD sector writes: one start pulse per
// sector, one data word per controller request, ring-addressed sectors.
module eth_sd_sector_writer #(
    parameter int          SECTOR_WORDS = 128,
    parameter logic [31:0] START_SECTOR = 32'd8192,
    parameter logic [31:0] MAX_SECTORS  = 32'd65536
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    input  logic        enable,
    input  logic        sd_init_done,
    input  logic        fifo_rd_vld,
    input  logic [31:0] fifo_rd_data,
    output logic        fifo_rd_en,
    output logic        sd_wr_start,
    output logic [31:0] sd_wr_sec_addr,
    input  logic        sd_wr_busy,
    input  logic        sd_wr_req,
    output logic [31:0] sd_wr_data,
    output logic [31:0] sec_cnt,
    output logic        underrun,
    output logic        active
);

    localparam int          WCW       = $clog2(SECTOR_WORDS) + 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(SECTOR_WORDS - 1);
    localparam logic [31:0] LAST_ADDR = START_SECTOR + MAX_SECTORS - 32'd1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_WAIT_DONE} state_t;

    state_t         r_state, w_next;
    logic [31:0]    r_cur_addr;
    logic [WCW-1:0] r_word_cnt;
    logic           r_seen_busy;
    logic [31:0]    r_sec_addr;
    logic [31:0]    r_wr_data;
    logic [31:0]    r_sec_cnt;
    logic           r_underrun;
    logic           w_pop;
    logic           w_take_req;
    logic           w_done;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_pop      = 1'b0;
        w_take_req = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && sd_init_done && fifo_rd_vld && !sd_wr_busy)
                    w_next = S_START;
            end
            S_START: w_next = S_XFER;
            S_XFER: begin
                if (sd_wr_req) begin
                    w_take_req = 1'b1;
                    w_pop      = fifo_rd_vld;
                    if (r_word_cnt == LAST_WORD) w_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // Busy must have been observed high first, so an idle controller
                // cannot complete the sector before it has even started writing.
                if (r_seen_busy && !sd_wr_busy) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            r_cur_addr  <= START_SECTOR;
            r_word_cnt  <= '0;
            r_seen_busy <= 1'b0;
            r_sec_addr  <= START_SECTOR;
            r_wr_data   <= 32'd0;
            r_sec_cnt   <= 32'd0;
            r_underrun  <= 1'b0;
        end else begin
            // Latch the address on the way into START so it is already valid
            // during the start pulse.
            if (r_state == S_IDLE && w_next == S_START)
                r_sec_addr <= r_cur_addr;

            if (r_state == S_START)
                r_word_cnt <= '0;
            else if (w_take_req)
                r_word_cnt <= r_word_cnt + 1'b1;

            if (w_take_req) begin
                if (fifo_rd_vld) begin
                    r_wr_data <= fifo_rd_data;
                end else begin
                    r_wr_data  <= 32'd0;
                    r_underrun <= 1'b1;
                end
            end

            if (w_done)
                r_seen_busy <= 1'b0;
            else if ((r_state == S_START || r_state == S_XFER) && sd_wr_busy)
                r_seen_busy <= 1'b1;

            if (w_done) begin
                r_sec_cnt  <= r_sec_cnt + 32'd1;
                r_cur_addr <= (r_cur_addr == LAST_ADDR) ? START_SECTOR : r_cur_addr + 32'd1;
            end
        end
    end

    assign fifo_rd_en     = w_pop;
    assign sd_wr_start    = (r_state == S_START);
    assign sd_wr_sec_addr = r_sec_addr;
    assign sd_wr_data     = r_wr_data;
    assign sec_cnt        = r_sec_cnt;
    assign underrun       = r_underrun;
    assign active         = (r_state != S_IDLE);

endmodule
